// File: rtl/fixed_adder_tree_pipe.sv
// Pipelined N-input signed adder tree: one register per tree level, global valid/ready stall,
// and saturating or wrapping narrowing of the full-precision sum into OUT_WIDTH bits.
module fixed_adder_tree_pipe #(
    parameter int N_INPUTS  = 3,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 35,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_INPUTS*IN_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_overflow
);
    localparam int LEVELS = $clog2(N_INPUTS);
    localparam int FULL_W = IN_WIDTH + LEVELS;

    typedef logic [N_INPUTS-1:0][FULL_W-1:0] vec_t;

    if (N_INPUTS < 2 || N_INPUTS > 16 || OUT_WIDTH < IN_WIDTH) begin : g_param_check
        $error("fixed_adder_tree_pipe: N_INPUTS must be 2..16 and OUT_WIDTH >= IN_WIDTH");
    end

    // Number of live elements entering tree level k.
    function automatic int unsigned width_at(input int unsigned k);
        return (N_INPUTS + (1 << k) - 1) >> k;
    endfunction

    function automatic vec_t pair_sum(input vec_t a, input int unsigned n);
        vec_t r;
        r = '0;
        for (int unsigned j = 0; j < N_INPUTS; j++) begin
            if (2 * j + 1 < n)
                r[j] = a[2 * j] + a[2 * j + 1];
            else if (2 * j < n)
                r[j] = a[2 * j];
        end
        return r;
    endfunction

    // The last level always sees exactly two live elements since 2^(LEVELS-1) < N_INPUTS.
    function automatic logic [FULL_W-1:0] tree_tail(input vec_t a);
        logic [FULL_W-1:0] s;
        s = '0;
        for (int unsigned j = 0; j < 2; j++)
            s = s + a[j];
        return s;
    endfunction

    vec_t                     ext;
    logic signed [FULL_W-1:0] full_sum;
    logic                     last_v;
    logic [OUT_WIDTH-1:0]     narrow;
    logic                     ovf;

    assign in_ready = !out_valid || out_ready;

    always_comb begin
        ext = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++)
            ext[i] = FULL_W'(signed'(in_data[i*IN_WIDTH +: IN_WIDTH]));
    end

    if (LEVELS == 1) begin : g_flat
        always_comb begin
            full_sum = tree_tail(ext);
            last_v   = in_valid;
        end
    end else begin : g_stages
        vec_t              stg_q [LEVELS-1];
        logic [LEVELS-2:0] stg_v;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_v <= '0;
                for (int unsigned k = 0; k < LEVELS - 1; k++)
                    stg_q[k] <= '0;
            end else begin
                if (clear) begin
                    stg_v <= '0;
                end else if (in_ready) begin
                    stg_v[0] <= in_valid;
                    for (int unsigned k = 1; k < LEVELS - 1; k++)
                        stg_v[k] <= stg_v[k-1];
                end
                if (in_ready) begin
                    stg_q[0] <= pair_sum(ext, N_INPUTS);
                    for (int unsigned k = 1; k < LEVELS - 1; k++)
                        stg_q[k] <= pair_sum(stg_q[k-1], width_at(k));
                end
            end
        end

        always_comb begin
            full_sum = tree_tail(stg_q[LEVELS-2]);
            last_v   = stg_v[LEVELS-2];
        end
    end

    if (OUT_WIDTH >= FULL_W) begin : g_wide
        always_comb begin
            narrow = OUT_WIDTH'(full_sum);
            ovf    = 1'b0;
        end
    end else begin : g_narrow
        logic [FULL_W-OUT_WIDTH:0] top_bits;

        // The sum fits iff every bit from the OUT_WIDTH sign position upward agrees.
        always_comb begin
            top_bits = full_sum[FULL_W-1:OUT_WIDTH-1];
            ovf      = !((&top_bits) || !(|top_bits));
            narrow   = full_sum[OUT_WIDTH-1:0];
            if (ovf && SATURATE)
                narrow = full_sum[FULL_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
        end else if (clear) begin
            out_valid    <= 1'b0;
            out_overflow <= 1'b0;
        end else if (in_ready) begin
            out_valid    <= last_v;
            out_data     <= narrow;
            out_overflow <= last_v && ovf;
        end
    end
endmodule

// File: tb/tb_fixed_adder_tree_pipe.sv
// Bench for fixed_adder_tree_pipe: four configurations (3-input 35/33-bit sat/wrap, 16-input)
// checked with a vector table, handshake sequences and random traffic against an integer model.
module tb_fixed_adder_tree_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, clear, in_valid, out_ready;
    logic [95:0]  d3;
    logic [511:0] d16;
    logic         rdy_a, rdy_b, rdy_c, rdy_d;
    logic         ov_a, ov_b, ov_c, ov_d;
    logic         of_a, of_b, of_c, of_d;
    logic signed [34:0] od_a, od_d;
    logic signed [32:0] od_b, od_c;

    fixed_adder_tree_pipe #(.N_INPUTS(3), .IN_WIDTH(32), .OUT_WIDTH(35), .SATURATE(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(d3), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_overflow(of_a));
    fixed_adder_tree_pipe #(.N_INPUTS(3), .IN_WIDTH(32), .OUT_WIDTH(33), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(d3), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_overflow(of_b));
    fixed_adder_tree_pipe #(.N_INPUTS(3), .IN_WIDTH(32), .OUT_WIDTH(33), .SATURATE(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(d3), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_overflow(of_c));
    fixed_adder_tree_pipe #(.N_INPUTS(16), .IN_WIDTH(32), .OUT_WIDTH(35), .SATURATE(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_d),
        .in_data(d16), .out_valid(ov_d), .out_ready(out_ready), .out_data(od_d), .out_overflow(of_d));

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint a, b, c;
        longint sum;
        longint sat33;
        longint wrap33;
        bit     ovf33;
    } vec_rec_t;

    typedef struct {
        longint s35, s33, w33;
        bit     o33;
    } exp_t;

    vec_rec_t tbl [9];
    exp_t     q [$];
    exp_t     e;
    longint   got [$];
    longint   ra, rb, rc, s, m;
    longint   v16 [16];
    bit       o;
    int       seen;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        if (ov_a && out_ready)
            got.push_back(od_a);
        step();
    endtask

    task automatic pack3(input longint a, input longint b, input longint c);
        d3 = {c[31:0], b[31:0], a[31:0]};
    endtask

    task automatic pack16(input longint v [16]);
        for (int i = 0; i < 16; i++)
            d16[i*32 +: 32] = v[i][31:0];
    endtask

    // Integer reference: exact narrowing of a mathematical sum into an ow-bit signed field.
    function automatic longint narrow_m(input longint sum, input int ow, input bit sat, output bit ovf);
        longint lim, hi, lo, r;
        lim = longint'(1) << (ow - 1);
        hi  = lim - 1;
        lo  = -lim;
        ovf = (sum > hi) || (sum < lo);
        if (!ovf)
            r = sum;
        else if (sat)
            r = (sum > hi) ? hi : lo;
        else begin
            r = sum % (lim * 2);
            if (r > hi) r = r - lim * 2;
            if (r < lo) r = r + lim * 2;
        end
        return r;
    endfunction

    function automatic longint rnd_op();
        case ($urandom_range(0, 5))
            0: return 64'sd2147483647;
            1: return -64'sd2147483648;
            2: return -64'sd1;
            default: return longint'($signed($urandom()));
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        d3 = '0; d16 = '0;
        #1;
        do_reset();

        chk("rst_valid_a", ov_a, 0);   chk("rst_data_a", od_a, 0);   chk("rst_ovf_a", of_a, 0);
        chk("rst_valid_b", ov_b, 0);   chk("rst_data_b", od_b, 0);   chk("rst_valid_c", ov_c, 0);
        chk("rst_valid_d", ov_d, 0);   chk("rst_data_d", od_d, 0);   chk("rst_ovf_d", of_d, 0);
        chk("rst_ready_a", rdy_a, 1);  chk("rst_ready_d", rdy_d, 1);

        // {a, b, c, full sum, 33-bit saturated, 33-bit wrapped, 33-bit overflow}
        tbl[0] = '{64'sd5, -64'sd7, 64'sd100, 64'sd98, 64'sd98, 64'sd98, 1'b0};
        tbl[1] = '{64'sd2147483647, 64'sd2147483647, 64'sd2147483647,
                   64'sd6442450941, 64'sd4294967295, -64'sd2147483651, 1'b1};
        tbl[2] = '{-64'sd2147483648, -64'sd2147483648, -64'sd2147483648,
                   -64'sd6442450944, -64'sd4294967296, 64'sd2147483648, 1'b1};
        tbl[3] = '{64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 1'b0};
        tbl[4] = '{-64'sd1, -64'sd1, -64'sd1, -64'sd3, -64'sd3, -64'sd3, 1'b0};
        tbl[5] = '{64'sd2147483647, 64'sd2147483647, 64'sd1,
                   64'sd4294967295, 64'sd4294967295, 64'sd4294967295, 1'b0};
        tbl[6] = '{64'sd2147483647, 64'sd2147483647, 64'sd2,
                   64'sd4294967296, 64'sd4294967295, -64'sd4294967296, 1'b1};
        tbl[7] = '{-64'sd2147483648, -64'sd2147483648, -64'sd1,
                   -64'sd4294967297, -64'sd4294967296, 64'sd4294967295, 1'b1};
        tbl[8] = '{-64'sd2147483648, -64'sd2147483648, 64'sd0,
                   -64'sd4294967296, -64'sd4294967296, -64'sd4294967296, 1'b0};

        for (int i = 0; i < 9; i++) begin
            pack3(tbl[i].a, tbl[i].b, tbl[i].c);
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), rdy_a, 1);
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_lat1_valid", i), ov_a, 0);
            step();
            chk($sformatf("tbl%0d_valid_a", i), ov_a, 1);
            chk($sformatf("tbl%0d_data_a", i), od_a, tbl[i].sum);
            chk($sformatf("tbl%0d_ovf_a", i), of_a, 0);
            chk($sformatf("tbl%0d_valid_b", i), ov_b, 1);
            chk($sformatf("tbl%0d_data_sat", i), od_b, tbl[i].sat33);
            chk($sformatf("tbl%0d_ovf_sat", i), of_b, tbl[i].ovf33);
            chk($sformatf("tbl%0d_data_wrap", i), od_c, tbl[i].wrap33);
            chk($sformatf("tbl%0d_ovf_wrap", i), of_c, tbl[i].ovf33);
            step();
        end

        // Streaming with a three-cycle stall right after the first result.
        got.delete();
        out_ready = 1'b1;
        pack3(1, 1, 1); in_valid = 1'b1; cyc();
        pack3(2, 2, 2); cyc();
        chk("strm_first_valid", ov_a, 1);
        out_ready = 1'b0;
        pack3(3, 3, 3);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("strm_stall%0d_ready", k), rdy_a, 0);
            chk($sformatf("strm_stall%0d_data", k), od_a, 3);
            chk($sformatf("strm_stall%0d_valid", k), ov_a, 1);
            cyc();
        end
        chk("strm_stall_end_data", od_a, 3);
        out_ready = 1'b1;
        cyc();
        pack3(4, 4, 4); cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("strm_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("strm_out%0d", k), got[k], 3 * (k + 1));

        // Random traffic on the three 3-input configurations.
        q.delete();
        for (int cy = 0; cy < 400; cy++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ra = rnd_op(); rb = rnd_op(); rc = rnd_op();
            pack3(ra, rb, rc);
            #1;
            if (ov_a && out_ready) begin
                if (q.size() == 0) chk("rnd_spurious", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rnd_data_a", od_a, e.s35);  chk("rnd_ovf_a", of_a, 0);
                    chk("rnd_data_b", od_b, e.s33);  chk("rnd_ovf_b", of_b, e.o33);
                    chk("rnd_data_c", od_c, e.w33);  chk("rnd_ovf_c", of_c, e.o33);
                end
            end
            if (in_valid && rdy_a) begin
                s = ra + rb + rc;
                e.s35 = narrow_m(s, 35, 1'b1, o);
                e.s33 = narrow_m(s, 33, 1'b1, e.o33);
                e.w33 = narrow_m(s, 33, 1'b0, o);
                q.push_back(e);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cy = 0; cy < 10; cy++) begin
            if (ov_a) begin
                if (q.size() == 0) chk("rnd_drain_spurious", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rnd_drain_data_a", od_a, e.s35);
                    chk("rnd_drain_data_c", od_c, e.w33);
                end
            end
            step();
        end
        chk("rnd_drain_empty", q.size(), 0);

        // 16-input configuration: latency 4, random vectors with narrowing at 35 bits.
        do_reset();
        for (int t = 0; t < 6; t++) begin
            s = 0;
            for (int i = 0; i < 16; i++) begin
                v16[i] = rnd_op();
                s += v16[i];
            end
            m = narrow_m(s, 35, 1'b1, o);
            pack16(v16);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step(); step();
            chk($sformatf("n16_%0d_lat3_valid", t), ov_d, 0);
            step();
            chk($sformatf("n16_%0d_valid", t), ov_d, 1);
            chk($sformatf("n16_%0d_data", t), od_d, m);
            chk($sformatf("n16_%0d_ovf", t), of_d, o);
            step();
        end

        // Flush with two vectors in flight, then clear coinciding with an acceptance.
        for (int i = 0; i < 16; i++) v16[i] = 7;
        pack16(v16);
        in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0; clear = 1'b1;
        #1;
        chk("clr_ready_during", rdy_d, 1);
        step();
        clear = 1'b0;
        seen = 0;
        repeat (8) begin if (ov_d) seen++; step(); end
        chk("clr_no_valid", seen, 0);
        in_valid = 1'b1; clear = 1'b1;
        step();
        in_valid = 1'b0; clear = 1'b0;
        seen = 0;
        repeat (8) begin if (ov_d) seen++; step(); end
        chk("clr_drop_accept", seen, 0);
        for (int i = 0; i < 16; i++) v16[i] = 1;
        pack16(v16);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("clr_after_lat3_valid", ov_d, 0);
        step();
        chk("clr_after_valid", ov_d, 1);
        chk("clr_after_data", od_d, 16);
        step();

        // Asynchronous reset mid-stream.
        in_valid = 1'b1;
        repeat (6) step();
        chk("rstm_pre_valid", ov_d, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm_valid", ov_d, 0);
        chk("rstm_data", od_d, 0);
        chk("rstm_ovf", of_d, 0);
        chk("rstm_valid_a", ov_a, 0);
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rstm_ready_after", rdy_d, 1);
        seen = 0;
        repeat (8) begin if (ov_d || ov_a) seen++; step(); end
        chk("rstm_no_stale", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fixed_adder_tree_pipe.md
Name: fixed_adder_tree_pipe

Overview:
Parametrised, pipelined N-input signed fixed-point adder tree for the fpmac datapath. It is the successor to the single-cycle 3-operand combinational adder and generalises it in three ways:
- configurable operand count;
- one register per tree level, with valid/ready backpressure;
- selectable saturating or wrapping output narrowing, with an overflow flag.

It sits between the partial-product/alignment stage and the normaliser.

Parameters:
- N_INPUTS, 3: number of signed operands; legal range 2..16.
- IN_WIDTH, 32: width of each operand, two's complement.
- OUT_WIDTH, 35: result width; must be >= IN_WIDTH.
- SATURATE, 1: 1 = clamp to the OUT_WIDTH signed range on overflow; 0 = keep the low OUT_WIDTH bits (wrap).
- Derived, not overridable:
  - LEVELS = ceil(log2(N_INPUTS)).
  - FULL_W = IN_WIDTH + LEVELS.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous flush of all in-flight data.
- in_valid, input, 1: operand vector valid.
- in_ready, output, 1: block accepts the vector this cycle.
- in_data, input, N_INPUTS*IN_WIDTH: packed operands; operand i is in_data[i*IN_WIDTH +: IN_WIDTH].
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, OUT_WIDTH: signed sum.
- out_overflow, output, 1: full-precision sum did not fit in OUT_WIDTH; qualified by out_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits, out_valid, out_data and out_overflow go to 0;
  - in_ready is 1 one cycle after release (out_valid = 0).
- Elaboration check: N_INPUTS < 2, N_INPUTS > 16 or OUT_WIDTH < IN_WIDTH triggers $error then $finish.
- Arithmetic:
  - operands are sign-extended to FULL_W, so no intermediate overflow is possible.
  - Level k adds element pairs (2j, 2j+1). An odd leftover element passes through that level registered, unchanged.
  - Level outputs are registered, one register stage per level.
- Latency: exactly LEVELS cycles from an accepted input to out_valid (N=3 gives 2; N=16 gives 4).
- Narrowing, applied combinationally in the last level before its register:
  - OUT_WIDTH >= FULL_W: sign-extend; out_overflow is always 0.
  - Otherwise, overflow = sum > 2^(OUT_WIDTH-1)-1 or sum < -2^(OUT_WIDTH-1).
  - SATURATE=1: on overflow, clamp to the max/min positive/negative value.
  - SATURATE=0: keep the low OUT_WIDTH bits.
  - out_overflow is set in both modes.
- Handshake:
  - in_ready = !out_valid || out_ready, a single global stall.
  - Every stage register (data and valid) advances only when in_ready = 1.
  - A transfer occurs when valid && ready on the same edge.
  - Bubbles (in_valid = 0 while in_ready = 1) shift a 0 valid bit through the pipe.
- Stall: while out_valid && !out_ready, out_data, out_overflow, out_valid and all internal stages hold. in_data is ignored that cycle.
- Throughput: one result per cycle while out_ready stays high.
- clear:
  - at the next edge, all valid bits and out_valid go to 0 and out_overflow goes to 0. Data registers need not be cleared.
  - clear has priority over a simultaneous input acceptance; that vector is dropped.
  - in_ready is still driven by the formula above during clear.
- Reset mid-operation: all in-flight results are lost and no spurious out_valid appears after release.
- Data registers may lack reset only if out_data is still guaranteed 0 after reset. Requirement: out_data = 0 after reset.

Test Plan (N_INPUTS=3, IN_WIDTH=32, OUT_WIDTH=35 unless stated):
- Basic sum: operands 5, -7, 100 with out_ready=1 -> out_data=98 exactly 2 cycles after acceptance, out_overflow=0.
- Extremes, no overflow:
  - three operands of 0x7FFFFFFF -> out_data=0x17FFFFFFD (6442450941);
  - three operands of 0x80000000 -> out_data=-6442450944;
  - out_overflow=0 in both cases.
- Saturation (OUT_WIDTH=33, SATURATE=1): three operands of 0x7FFFFFFF -> out_data=0x0FFFFFFFF (4294967295), out_overflow=1; three operands of 0x80000000 -> out_data=-4294967296, out_overflow=1.
- Wrap (OUT_WIDTH=33, SATURATE=0): three operands of 0x7FFFFFFF -> out_data=-2147483651 (low 33 bits 0x17FFFFFFD), out_overflow=1.
- Backpressure and streaming:
  - stream the vectors {1,1,1}, {2,2,2}, {3,3,3}, {4,4,4} back-to-back;
  - hold out_ready=0 for 3 cycles after the first result;
  - required: outputs 3, 6, 9, 12 appear in order with none lost or duplicated, out_data is stable during the stall, and in_ready=0 while stalled.
- Flush and reset (N_INPUTS=16, latency 4):
  - assert clear with 2 vectors in flight -> no out_valid for them; the next vector of all 1s gives out_data=16, 4 cycles later;
  - drop rst_n mid-stream -> outputs 0 immediately (asynchronously), no stale result after release.
